// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the SPI responder byte engine.
package spi_pkg;

    localparam logic       CPOL_IDLE_LOW    = 1'b0;
    localparam logic       CPOL_IDLE_HIGH   = 1'b1;
    localparam logic       CPHA_LEAD_SAMPLE = 1'b0;
    localparam logic       CPHA_LEAD_DRIVE  = 1'b1;
    localparam int         SYNC_STAGES_DEF  = 2;
    localparam logic [7:0] FILL_BYTE_DEF    = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_byte_if.sv
// FIFO-side port bundle: show-ahead tx FIFO read port and rx FIFO write port.
interface spi_slave_byte_if;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_rdreq;
    logic [7:0] rx_data;
    logic       rx_wrreq;
    logic       rx_full;

    modport slave (
        input  tx_data, tx_empty, rx_full,
        output tx_rdreq, rx_data, rx_wrreq
    );

    modport master (
        output tx_data, tx_empty, rx_full,
        input  tx_rdreq, rx_data, rx_wrreq
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic n_rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= {STAGES{RST_VAL}};
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_byte.sv
// SPI responder byte engine: oversampled sclk/mosi/n_cs, MOSI bytes to the rx FIFO,
// show-ahead tx FIFO bytes out on MISO, MSB first.
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter logic       CPOL        = CPOL_IDLE_LOW,
    parameter logic       CPHA        = CPHA_LEAD_SAMPLE,
    parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEF,
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    n_rst,
    input  logic                    sys_clk,
    input  logic                    n_cs,
    input  logic                    sclk,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    output logic [7:0]              byte_cnt,
    output logic                    frame_end,
    output logic                    frame_partial,
    output logic                    tx_underrun,
    output logic                    rx_overflow,
    spi_slave_byte_if.slave         fifo
);
    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       load_pending_q, load_pending_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_oe_q, miso_oe_d;
    logic       rx_wrreq_q, rx_wrreq_d;
    logic       rx_overflow_q, rx_overflow_d;
    logic       tx_rdreq_q, tx_rdreq_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       frame_end_q, frame_end_d;
    logic       frame_partial_q, frame_partial_d;

    logic       sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s, mosi_s;
    logic       sclk_lvl_unused, ncs_lvl_unused;
    logic [1:0] mosi_edge_unused;
    logic       lead_s, trail_s, sample_ev_s, drive_ev_s;
    logic       load_s, shift_s, sample_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .sys_clk(sys_clk), .n_rst(n_rst), .d_i(sclk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .sys_clk(sys_clk), .n_rst(n_rst), .d_i(n_cs),
        .q_o(ncs_lvl_unused), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .sys_clk(sys_clk), .n_rst(n_rst), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1])
    );

    assign lead_s      = (CPOL == CPOL_IDLE_HIGH) ? sclk_fall_s : sclk_rise_s;
    assign trail_s     = (CPOL == CPOL_IDLE_HIGH) ? sclk_rise_s : sclk_fall_s;
    assign sample_ev_s = (CPHA == CPHA_LEAD_DRIVE) ? trail_s : lead_s;
    assign drive_ev_s  = (CPHA == CPHA_LEAD_DRIVE) ? lead_s : trail_s;

    // State and datapath registers; tx_sr idles at the fill byte so the pad idles at its MSB.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 3'd0;
            byte_cnt_q      <= 8'd0;
            tx_sr_q         <= FILL_BYTE;
            rx_sr_q         <= 8'd0;
            rx_data_q       <= 8'd0;
            load_pending_q  <= 1'b0;
            byte_done_q     <= 1'b0;
            miso_oe_q       <= 1'b0;
            rx_wrreq_q      <= 1'b0;
            rx_overflow_q   <= 1'b0;
            tx_rdreq_q      <= 1'b0;
            tx_underrun_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            frame_partial_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            tx_sr_q         <= tx_sr_d;
            rx_sr_q         <= rx_sr_d;
            rx_data_q       <= rx_data_d;
            load_pending_q  <= load_pending_d;
            byte_done_q     <= byte_done_d;
            miso_oe_q       <= miso_oe_d;
            rx_wrreq_q      <= rx_wrreq_d;
            rx_overflow_q   <= rx_overflow_d;
            tx_rdreq_q      <= tx_rdreq_d;
            tx_underrun_q   <= tx_underrun_d;
            frame_end_q     <= frame_end_d;
            frame_partial_q <= frame_partial_d;
        end
    end

    // Next-state logic: frame control, byte handoff, tx load/shift and rx sampling.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        tx_sr_d         = tx_sr_q;
        rx_sr_d         = rx_sr_q;
        rx_data_d       = rx_data_q;
        load_pending_d  = load_pending_q;
        byte_done_d     = 1'b0;
        miso_oe_d       = miso_oe_q;
        rx_wrreq_d      = 1'b0;
        rx_overflow_d   = 1'b0;
        tx_rdreq_d      = 1'b0;
        tx_underrun_d   = 1'b0;
        frame_end_d     = 1'b0;
        frame_partial_d = 1'b0;
        load_s          = 1'b0;
        shift_s         = 1'b0;
        sample_s        = 1'b0;

        if (byte_done_q) begin
            rx_data_d      = rx_sr_q;
            rx_wrreq_d     = 1'b1;
            rx_overflow_d  = fifo.rx_full;
            byte_cnt_d     = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
            load_pending_d = 1'b1;
        end else begin
            rx_wrreq_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall_s) begin
                    state_d        = ST_ACTIVE;
                    bit_cnt_d      = 3'd0;
                    byte_cnt_d     = 8'd0;
                    miso_oe_d      = 1'b1;
                    load_pending_d = (CPHA == CPHA_LEAD_DRIVE);
                    load_s         = (CPHA != CPHA_LEAD_DRIVE);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // Deselect takes priority; any sclk edge in the same cycle is dropped.
                if (ncs_rise_s) begin
                    state_d         = ST_IDLE;
                    miso_oe_d       = 1'b0;
                    frame_end_d     = 1'b1;
                    frame_partial_d = (bit_cnt_q != 3'd0);
                    load_pending_d  = 1'b0;
                end else begin
                    sample_s = sample_ev_s;
                    if (drive_ev_s && load_pending_q) begin
                        load_s         = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        shift_s = drive_ev_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            if (!fifo.tx_empty) begin
                tx_sr_d    = fifo.tx_data;
                tx_rdreq_d = 1'b1;
            end else begin
                tx_sr_d       = FILL_BYTE;
                tx_underrun_d = 1'b1;
            end
        end else if (shift_s) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end else begin
            tx_sr_d = tx_sr_q;
        end

        if (sample_s) begin
            rx_sr_d     = {rx_sr_q[6:0], mosi_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end else begin
            byte_done_d = 1'b0;
        end
    end

    assign miso          = tx_sr_q[7];
    assign miso_oe       = miso_oe_q;
    assign byte_cnt      = byte_cnt_q;
    assign frame_end     = frame_end_q;
    assign frame_partial = frame_partial_q;
    assign tx_underrun   = tx_underrun_q;
    assign rx_overflow   = rx_overflow_q;
    assign fifo.tx_rdreq = tx_rdreq_q;
    assign fifo.rx_data  = rx_data_q;
    assign fifo.rx_wrreq = rx_wrreq_q;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: one DUT per SPI mode, a bit-banged master and FIFO models.
module tb_spi_slave_byte;
    localparam int H = 8;

    logic sys_clk = 1'b0;
    logic n_rst   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       n_cs_a [4];
    logic       sclk_a [4];
    logic       mosi_a [4];
    logic       miso_a [4];
    logic       oe_a   [4];
    logic       rdreq_a[4];
    logic       wrreq_a[4];
    logic       fend_a [4];
    logic       fpart_a[4];
    logic       unr_a  [4];
    logic       ovf_a  [4];
    logic [7:0] rxd_a  [4];
    logic [7:0] bcnt_a [4];

    logic [7:0] tx_mem[8];
    int         tx_wr = 0;
    int         tx_rd = 0;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       rx_full = 1'b0;
    assign tx_head  = tx_mem[tx_rd[2:0]];
    assign tx_empty = (tx_rd == tx_wr);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            spi_slave_byte_if fif();
            assign fif.tx_data  = tx_head;
            assign fif.tx_empty = tx_empty;
            assign fif.rx_full  = rx_full;
            assign rdreq_a[g]   = fif.tx_rdreq;
            assign wrreq_a[g]   = fif.rx_wrreq;
            assign rxd_a[g]     = fif.rx_data;
            spi_slave_byte #(
                .CPOL((g & 2) != 0), .CPHA((g & 1) != 0),
                .FILL_BYTE(8'hFF), .SYNC_STAGES(2)
            ) u_dut (
                .n_rst(n_rst), .sys_clk(sys_clk), .n_cs(n_cs_a[g]), .sclk(sclk_a[g]),
                .mosi(mosi_a[g]), .miso(miso_a[g]), .miso_oe(oe_a[g]), .byte_cnt(bcnt_a[g]),
                .frame_end(fend_a[g]), .frame_partial(fpart_a[g]), .tx_underrun(unr_a[g]),
                .rx_overflow(ovf_a[g]), .fifo(fif)
            );
        end
    endgenerate

    int         cur = 0;
    logic       in_frame = 1'b0;
    logic       drive_phase = 1'b1;
    int         n_rd = 0, n_wr = 0, n_unr = 0, n_fend = 0, n_ovf = 0, n_ovfwr = 0, n_viol = 0;
    logic       last_part = 1'b0;
    logic       miso_prev = 1'b1;
    logic [7:0] rxq[$];

    // Monitor of the active DUT: FIFO pops, rx captures, pulse counts, miso-change legality.
    always @(negedge sys_clk) begin
        if (rdreq_a[cur]) begin
            tx_rd = tx_rd + 1;
            n_rd  = n_rd + 1;
        end
        if (wrreq_a[cur]) begin
            rxq.push_back(rxd_a[cur]);
            n_wr = n_wr + 1;
        end
        if (ovf_a[cur]) n_ovf = n_ovf + 1;
        if (ovf_a[cur] && wrreq_a[cur]) n_ovfwr = n_ovfwr + 1;
        if (unr_a[cur]) n_unr = n_unr + 1;
        if (fend_a[cur]) begin
            n_fend    = n_fend + 1;
            last_part = fpart_a[cur];
        end
        if (in_frame && (miso_a[cur] !== miso_prev) && !drive_phase) n_viol = n_viol + 1;
        miso_prev = miso_a[cur];
    end

    int n_chk = 0;
    int n_fail = 0;
    int b_rd, b_wr, b_unr, b_fend, b_ovf, b_ovfwr, b_viol, b_rxq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic snap();
        b_rd = n_rd; b_wr = n_wr; b_unr = n_unr; b_fend = n_fend;
        b_ovf = n_ovf; b_ovfwr = n_ovfwr; b_viol = n_viol; b_rxq = rxq.size();
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr[2:0]] = b;
        tx_wr = tx_wr + 1;
    endtask

    function automatic logic [23:0] outs(input int m);
        return {miso_a[m], oe_a[m], rdreq_a[m], wrreq_a[m], rxd_a[m], bcnt_a[m],
                fend_a[m], fpart_a[m], unr_a[m], ovf_a[m]};
    endfunction

    // Bit-banged master: nbits taken MSB-first from mo, miso bits collected into mi.
    task automatic run_frame(input int m, input int nbits, input logic [15:0] mo,
                             output logic [15:0] mi);
        logic cpol;
        logic cpha;
        cpol = m[1];
        cpha = m[0];
        mi = 16'h0000;
        in_frame = 1'b1;
        drive_phase = 1'b1;
        n_cs_a[m] = 1'b0;
        wait_cyc(2 * H);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = mo[15 - i];
            if (!cpha) begin
                mosi_a[m] = b;
                wait_cyc(H);
                mi = {mi[14:0], miso_a[m]};
                drive_phase = 1'b0;
                sclk_a[m] = ~cpol;
                wait_cyc(H);
                drive_phase = 1'b1;
                sclk_a[m] = cpol;
            end else begin
                wait_cyc(H);
                drive_phase = 1'b1;
                sclk_a[m] = ~cpol;
                mosi_a[m] = b;
                wait_cyc(H);
                mi = {mi[14:0], miso_a[m]};
                drive_phase = 1'b0;
                sclk_a[m] = cpol;
            end
        end
        wait_cyc(2 * H);
        in_frame = 1'b0;
        n_cs_a[m] = 1'b1;
    endtask

    logic [15:0] mi;

    initial begin
        for (int m = 0; m < 4; m++) begin
            n_cs_a[m] = 1'b1;
            sclk_a[m] = m[1];
            mosi_a[m] = 1'b0;
        end
        n_rst = 1'b0;
        wait_cyc(4);
        for (int m = 0; m < 4; m++) check($sformatf("reset_m%0d", m), {8'h0, outs(m)}, 32'h0080_0000);
        n_rst = 1'b1;
        wait_cyc(4);

        // Two-byte frame in each mode: tx A5,3C; master sends 5A,C3.
        for (int m = 0; m < 4; m++) begin
            cur = m;
            wait_cyc(2);
            push_tx(8'hA5);
            push_tx(8'h3C);
            snap();
            run_frame(m, 16, 16'h5AC3, mi);
            wait_cyc(8);
            check($sformatf("m%0d_miso", m), {16'h0, mi}, 32'h0000_A53C);
            check($sformatf("m%0d_nwr", m), n_wr - b_wr, 2);
            check($sformatf("m%0d_rx0", m), {24'h0, rxq[b_rxq]}, 32'h5A);
            check($sformatf("m%0d_rx1", m), {24'h0, rxq[b_rxq + 1]}, 32'hC3);
            check($sformatf("m%0d_nrd", m), n_rd - b_rd, 2);
            check($sformatf("m%0d_bcnt", m), {24'h0, bcnt_a[m]}, 32'd2);
            check($sformatf("m%0d_fend", m), n_fend - b_fend, 1);
            check($sformatf("m%0d_part", m), {31'h0, last_part}, 32'd0);
            check($sformatf("m%0d_unr", m), n_unr - b_unr, (m % 2 == 0) ? 1 : 0);
            check($sformatf("m%0d_drive_edge", m), n_viol - b_viol, 0);
        end

        // Empty tx FIFO, one byte, mode 1.
        cur = 1;
        wait_cyc(2);
        snap();
        run_frame(1, 8, 16'h9600, mi);
        wait_cyc(8);
        check("empty_miso", {24'h0, mi[7:0]}, 32'hFF);
        check("empty_unr", n_unr - b_unr, 1);
        check("empty_nrd", n_rd - b_rd, 0);
        check("empty_rx", {24'h0, rxq[b_rxq]}, 32'h96);

        // Deselect after five bits, mode 0.
        cur = 0;
        wait_cyc(2);
        snap();
        run_frame(0, 5, 16'hF800, mi);
        check("part_oe_before", {31'h0, oe_a[0]}, 32'd1);
        wait_cyc(4);
        check("part_oe_after", {31'h0, oe_a[0]}, 32'd0);
        wait_cyc(4);
        check("part_nwr", n_wr - b_wr, 0);
        check("part_fend", n_fend - b_fend, 1);
        check("part_flag", {31'h0, last_part}, 32'd1);

        // rx_full during byte 81, then a clean frame.
        rx_full = 1'b1;
        snap();
        run_frame(0, 8, 16'h8100, mi);
        wait_cyc(8);
        rx_full = 1'b0;
        check("ovf_count", n_ovf - b_ovf, 1);
        check("ovf_with_wr", n_ovfwr - b_ovfwr, 1);
        check("ovf_nwr", n_wr - b_wr, 1);
        snap();
        run_frame(0, 8, 16'h4200, mi);
        wait_cyc(8);
        check("after_ovf_rx", {24'h0, rxq[b_rxq]}, 32'h42);
        check("after_ovf_cnt", n_ovf - b_ovf, 0);

        // Asynchronous reset in the middle of a byte, then a clean frame.
        snap();
        n_cs_a[0] = 1'b0;
        wait_cyc(2 * H);
        for (int i = 0; i < 4; i++) begin
            mosi_a[0] = i[0];
            wait_cyc(H);
            sclk_a[0] = 1'b1;
            wait_cyc(H);
            sclk_a[0] = 1'b0;
        end
        wait_cyc(3);
        n_rst = 1'b0;
        wait_cyc(1);
        check("rst_mid_outs", {8'h0, outs(0)}, 32'h0080_0000);
        n_cs_a[0] = 1'b1;
        wait_cyc(4);
        n_rst = 1'b1;
        wait_cyc(8);
        check("rst_no_fend", n_fend - b_fend, 0);
        check("rst_no_wr", n_wr - b_wr, 0);
        snap();
        run_frame(0, 8, 16'h0F00, mi);
        wait_cyc(8);
        check("rst_rx", {24'h0, rxq[b_rxq]}, 32'h0F);
        check("rst_bcnt", {24'h0, bcnt_a[0]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_byte.md
Name: spi_slave_byte

Overview:
- SPI responder (slave) engine. It is the counterpart of the team's SPI master byte engine. Lets the FPGA be addressed by an external SPI master.
- Oversamples sclk, mosi and n_cs in the sys_clk domain and deserialises MOSI bytes into an rx FIFO write port.
- Serialises bytes from a show-ahead tx FIFO onto MISO, MSB first.
- Sits between the board-level SPI pins and the per-channel rx/tx fifo_spi instances.

Parameters:
- CPOL, 1'b0, idle level of sclk.
- CPHA, 1'b0. 0 = sample on leading edge and drive on trailing edge; 1 = drive on leading edge and sample on trailing edge.
- FILL_BYTE, 8'hFF, byte shifted out when the tx FIFO is empty at a byte load.
- SYNC_STAGES, 2, synchroniser depth for sclk, mosi and n_cs (minimum 2).

Ports:
- n_rst  input  1  asynchronous reset, active low.
- sys_clk  input  1  system clock; must be at least 8x the sclk frequency.
- n_cs  input  1  chip select from the external master, active low.
- sclk  input  1  SPI clock from the external master.
- mosi  input  1  serial data in.
- miso  output  1  serial data out.
- miso_oe  output  1  tri-state enable for the miso pad; 1 = drive.
- tx_data  input  8  head of the show-ahead tx FIFO.
- tx_empty  input  1  tx FIFO empty.
- tx_rdreq  output  1  one-cycle pop of the tx FIFO.
- rx_data  output  8  received byte.
- rx_wrreq  output  1  one-cycle write strobe to the rx FIFO.
- rx_full  input  1  rx FIFO full.
- byte_cnt  output  8  completed bytes in the current frame.
- frame_end  output  1  one-cycle pulse when n_cs deasserts.
- frame_partial  output  1  qualifies frame_end: deassert happened mid-byte.
- tx_underrun  output  1  one-cycle pulse: FILL_BYTE was loaded.
- rx_overflow  output  1  one-cycle pulse: byte completed while rx_full.

Behaviour:
- Reset values:
  - all outputs 0, except miso = FILL_BYTE[7];
  - state IDLE, bit_cnt 0, shift registers cleared.
- Input synchronisation and edges:
  - sclk, mosi and n_cs each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised sclk.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - sample_ev and drive_ev are derived from CPHA.
- State machine: IDLE, ACTIVE.
  - IDLE -> ACTIVE on the synchronised n_cs falling edge. On this transition:
    - bit_cnt <= 0, byte_cnt <= 0, miso_oe <= 1.
    - CPHA=0: tx byte is loaded immediately (the first bit must be valid before the first leading edge).
    - CPHA=1: load_pending <= 1.
  - ACTIVE -> IDLE on the synchronised n_cs rising edge. On this transition:
    - miso_oe <= 0, frame_end pulse.
    - frame_partial = (bit_cnt != 0); the partial rx byte is discarded, no rx_wrreq.
  - sclk edges are ignored in IDLE.
- Tx byte load (same cycle in all cases):
  - if !tx_empty: tx_sr <= tx_data and tx_rdreq pulses;
  - else: tx_sr <= FILL_BYTE and tx_underrun pulses.
  - miso = tx_sr[7] at all times.
- On drive_ev (ACTIVE):
  - if load_pending, load a new byte and clear load_pending;
  - else shift tx_sr left by 1.
- On sample_ev (ACTIVE):
  - rx_sr <= {rx_sr[6:0], mosi_sync}; bit_cnt increments, wrapping 7 -> 0.
  - On the 8th sample (bit_cnt was 7), the next cycle:
    - rx_data <= completed byte, rx_wrreq pulses;
    - byte_cnt increments, saturating at 255;
    - load_pending <= 1, so the next drive_ev presents the next byte's MSB.
  - If rx_full at that moment: rx_wrreq is still pulsed (the FIFO drops the byte) and rx_overflow pulses.
- Latency:
  - pin edge to internal event: SYNC_STAGES+1 sys_clk cycles;
  - sclk edge to miso update: SYNC_STAGES+2 cycles, which is within half an sclk period at the 8x ratio.
- Simultaneous events:
  - n_cs rising wins over a same-cycle sclk edge; that edge is ignored.
  - An n_cs glitch shorter than SYNC_STAGES cycles is not required to be seen.
- Back-to-back frames: a new n_cs fall in the cycle after frame_end is accepted.
- Asynchronous reset mid-frame returns to reset values immediately; no strobes are emitted.

Decomposition:
- Package spi_pkg:
  - CPOL/CPHA encodings;
  - the SYNC_STAGES default;
  - the FILL_BYTE default;
  - state encoding (IDLE=1'b0, ACTIVE=1'b1).
- One sub-module, spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs. Instantiated for sclk and n_cs; mosi uses the synchroniser only.

Test Plan:
- Mode 0, sys_clk = 16x sclk. Tx FIFO holds 8'hA5, 8'h3C; master sends 8'h5A, 8'hC3 in one frame.
  -> miso reads A5, 3C; rx_wrreq x2 with 5A, C3; tx_rdreq x2; byte_cnt=2; frame_end=1 with frame_partial=0.
- Modes 1, 2 and 3 repeat the previous scenario.
  -> identical byte results; miso changes only on the drive edge for each mode.
- Tx FIFO empty, master sends 1 byte.
  -> miso reads 8'hFF; tx_underrun pulses once; no tx_rdreq.
- n_cs deasserted after 5 sclk cycles.
  -> no rx_wrreq; frame_end with frame_partial=1; miso_oe=0 within SYNC_STAGES+2 cycles.
- rx_full=1 during byte 8'h81.
  -> rx_wrreq and rx_overflow pulse in the same cycle; next frame unaffected.
- n_rst asserted mid-byte, released, then a clean mode-0 frame with 8'h0F.
  -> all outputs at reset values during reset; the following frame receives 8'h0F correctly.
